op_frame_receiver: RTL and testbench

//  UART receive end of the traveler operate link. Deserialises 8N1 frames from the operate-byte

---
 rtl/op_link_pkg.sv | 42 ++++
 rtl/op_frame_receiver_if.sv | 33 +++
 rtl/uart_rx_core.sv | 99 +++++++++
 rtl/op_frame_receiver.sv | 105 ++++++++++
 tb/tb_op_frame_receiver.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/op_link_pkg.sv
// Shared definitions for the traveler operate link.
//   OP_TAG        : value of byte[1:0] that marks an operate byte
//   OP_GET..THROW : one-hot 5-bit operate codes carried in byte[6:2]
//   OP_IGNORE     : all-zero code, a keep-alive that carries no command
//   op_byte_t     : field layout of a received link byte
//   rx_state_e    : receiver FSM states
package op_link_pkg;

  localparam int unsigned OP_CODE_W = 5;
  localparam int unsigned OP_BYTE_W = 8;

  localparam logic [1:0]           OP_TAG      = 2'b10;
  localparam logic [OP_CODE_W-1:0] OP_GET      = 5'b00001;
  localparam logic [OP_CODE_W-1:0] OP_PUT      = 5'b00010;
  localparam logic [OP_CODE_W-1:0] OP_INTERACT = 5'b00100;
  localparam logic [OP_CODE_W-1:0] OP_MOVE     = 5'b01000;
  localparam logic [OP_CODE_W-1:0] OP_THROW    = 5'b10000;
  localparam logic [OP_CODE_W-1:0] OP_IGNORE   = 5'b00000;

  typedef struct packed {
    logic                 spare;  // not interpreted by the receiver
    logic [OP_CODE_W-1:0] code;
    logic [1:0]           tag;
  } op_byte_t;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_e;

  // True only for the five legal single-command codes.
  function automatic logic is_op_code(input logic [OP_CODE_W-1:0] code);
    case (code)
      OP_GET, OP_PUT, OP_INTERACT, OP_MOVE, OP_THROW: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/op_frame_receiver_if.sv
// Receiver-side link bundle.
//   rx         : serial line into the receiver (idle high)
//   rx_byte    : last good byte
//   byte_valid : rx_byte updated this cycle
//   op_valid   : op_code holds a fresh command this cycle
//   op_code    : one-hot command, held between pulses
//   op_err     : tagged byte with a multi-hot code
//   frame_err  : stop bit sampled low
//   busy       : frame in progress
// master: the receiver; slave: the serial source / command consumer.
interface op_frame_receiver_if;
  import op_link_pkg::*;

  logic                 rx;
  logic [OP_BYTE_W-1:0] rx_byte;
  logic                 byte_valid;
  logic                 op_valid;
  logic [OP_CODE_W-1:0] op_code;
  logic                 op_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_byte, byte_valid, op_valid, op_code, op_err, frame_err, busy
  );

  modport slave (
    output rx,
    input  rx_byte, byte_valid, op_valid, op_code, op_err, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART deserialiser with 2-flop input synchroniser.
//   uart_clk, rst     : clock (OVERSAMPLE x baud), synchronous active-high reset
//   rx_i              : asynchronous serial line
//   byte_o            : shift register contents (complete when byte_strobe_c_o is high)
//   byte_strobe_c_o   : stop bit sampled high this cycle (combinational)
//   frame_err_c_o     : stop bit sampled low this cycle (combinational)
//   busy_o            : registered, validated start bit through end of stop bit
module uart_rx_core
  import op_link_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 uart_clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [OP_BYTE_W-1:0] byte_o,
  output logic                 byte_strobe_c_o,
  output logic                 frame_err_c_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

  logic                 rx_meta_q;
  logic                 rx_sync_q;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_idx_q;
  logic [OP_BYTE_W-1:0] shift_q;
  logic                 busy_q;
  logic                 cnt_last;
  logic                 cnt_half;
  logic                 stop_sample;

  assign cnt_last    = (cnt_q == CNT_W'(OVERSAMPLE - 1));
  assign cnt_half    = (cnt_q == CNT_W'(OVERSAMPLE / 2 - 1));
  assign stop_sample = (state_q == STOP) && cnt_last;

  // Synchroniser, sample counter and receive FSM.
  // Sync flops reset low so a line held low through reset never looks like a start bit.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      cnt_q     <= cnt_last ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        WAIT_IDLE: begin
          if (rx_sync_q) state_q <= IDLE;
        end
        IDLE: begin
          cnt_q <= '0;
          if (!rx_sync_q) state_q <= START;
        end
        START: begin
          // Mid-start-bit recheck rejects short glitches.
          if (cnt_half) begin
            cnt_q <= '0;
            if (rx_sync_q) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              busy_q    <= 1'b1;
            end
          end
        end
        DATA: begin
          // Counter is re-phased to the bit centre, so the wrap point is mid-bit.
          if (cnt_last) begin
            shift_q   <= {rx_sync_q, shift_q[OP_BYTE_W-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_last) begin
            busy_q  <= 1'b0;
            state_q <= rx_sync_q ? IDLE : WAIT_IDLE;
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign byte_o          = shift_q;
  assign byte_strobe_c_o = stop_sample && rx_sync_q;
  assign frame_err_c_o   = stop_sample && !rx_sync_q;
  assign busy_o          = busy_q;

endmodule

// File: rtl/op_frame_receiver.sv
// UART receive end of the traveler operate link: deserialises 8N1 frames and
// decodes tagged bytes into single-cycle one-hot operate command pulses.
//   uart_clk, rst : clock (OVERSAMPLE x baud), synchronous active-high reset
//   bus (master)  : rx in; rx_byte, byte_valid, op_valid, op_code, op_err,
//                   frame_err, busy out (all registered)
// Build option OP_RX_CHANGE_ONLY_EN: op_valid only fires when the one-hot code
// differs from the last accepted one; an IGNORE byte or reset clears that memory.
module op_frame_receiver
  import op_link_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                uart_clk,
  input  logic                rst,
  op_frame_receiver_if.master bus
);

  logic [OP_BYTE_W-1:0] core_byte;
  logic                 core_strobe_c;
  logic                 core_ferr_c;
  logic                 core_busy;

  uart_rx_core #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_core (
    .uart_clk        (uart_clk),
    .rst             (rst),
    .rx_i            (bus.rx),
    .byte_o          (core_byte),
    .byte_strobe_c_o (core_strobe_c),
    .frame_err_c_o   (core_ferr_c),
    .busy_o          (core_busy)
  );

  op_byte_t             rx_word_c;
  logic                 tagged_c;
  logic                 onehot_c;
  logic                 fire_c;
  logic                 op_valid_d;
  logic                 op_err_d;

  logic [OP_BYTE_W-1:0] rx_byte_q;
  logic                 byte_valid_q;
  logic                 op_valid_q;
  logic [OP_CODE_W-1:0] op_code_q;
  logic                 op_err_q;
  logic                 frame_err_q;

  assign rx_word_c = op_byte_t'(core_byte);
  assign tagged_c  = (rx_word_c.tag == OP_TAG);
  assign onehot_c  = is_op_code(rx_word_c.code);

`ifdef OP_RX_CHANGE_ONLY_EN
  logic [OP_CODE_W-1:0] last_code_q;

  assign fire_c = onehot_c && (rx_word_c.code != last_code_q);

  // Remember the last command; an IGNORE byte re-arms repeats of the same command.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      last_code_q <= OP_IGNORE;
    end else if (core_strobe_c && tagged_c) begin
      if (onehot_c) begin
        last_code_q <= rx_word_c.code;
      end else if (rx_word_c.code == OP_IGNORE) begin
        last_code_q <= OP_IGNORE;
      end
    end
  end
`else
  assign fire_c = onehot_c;
`endif

  assign op_valid_d = core_strobe_c && tagged_c && fire_c;
  assign op_err_d   = core_strobe_c && tagged_c && !onehot_c
                      && (rx_word_c.code != OP_IGNORE);

  // Output registers; rx_byte and op_code hold between pulses.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      op_valid_q   <= 1'b0;
      op_code_q    <= OP_IGNORE;
      op_err_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= core_strobe_c;
      op_valid_q   <= op_valid_d;
      op_err_q     <= op_err_d;
      frame_err_q  <= core_ferr_c;
      if (core_strobe_c) rx_byte_q <= rx_word_c;
      if (op_valid_d)    op_code_q <= rx_word_c.code;
    end
  end

  assign bus.rx_byte    = rx_byte_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.op_code    = op_code_q;
  assign bus.op_err     = op_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = core_busy;

endmodule

// File: tb/tb_op_frame_receiver.sv
// Self-checking bench for op_frame_receiver (OVERSAMPLE = 16).
// Inputs change on the falling clock edge; outputs are compared on the falling edge.
`timescale 1ns/1ps
module tb_op_frame_receiver;
  import op_link_pkg::*;

  localparam int unsigned OS = 16;
  // Falling edge that drives the start bit -> falling edge that sees byte_valid:
  // 1 (first rising edge) + 2 (synchroniser) + OS/2 (start check) + 9*OS (data+stop centre)
  // + 1 (output register) - 1 (commit edge shared) = 155.
  localparam int LAT      = 155;
  localparam int BUSY_ON  = 11;   // 1 + 2 + OS/2
  localparam int BUSY_END = 154;  // last falling edge with busy high

  typedef struct packed {
    logic       bv;
    logic       ov;
    logic       oe;
    logic       fe;
    logic [7:0] b;
    logic [4:0] code;
  } ev_t;

  logic uart_clk = 1'b0;
  logic rst;

  op_frame_receiver_if bus();

  op_frame_receiver #(.OVERSAMPLE(OS)) dut (
    .uart_clk (uart_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 uart_clk = ~uart_clk;

  // ---------------- model state ----------------
  ev_t        sched [int];
  int         busy_lo[$];
  int         busy_hi[$];
  logic [7:0] m_byte = 8'h00;
  logic [4:0] m_code = 5'b00000;
`ifdef OP_RX_CHANGE_ONLY_EN
  logic [4:0] m_last = 5'b00000;
`endif
  int cyc = 0;
  int rst_cyc = -1;
  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;
  int bv_cnt = 0, ov_cnt = 0, oe_cnt = 0, fe_cnt = 0;
  int last_bv_cyc = -1;

  always @(posedge uart_clk) cyc++;

  // Per-cycle comparison of every output against the model.
  always @(negedge uart_clk) begin
    ev_t         e;
    logic        exp_busy;
    logic [17:0] act;
    logic [17:0] exp;
    if (cyc == rst_cyc) begin
      m_byte = 8'h00;
      m_code = 5'b00000;
    end
    e = '0;
    if (sched.exists(cyc)) begin
      e = sched[cyc];
      if (e.bv) m_byte = e.b;
      if (e.ov) m_code = e.code;
    end
    exp_busy = 1'b0;
    foreach (busy_lo[i]) if (cyc >= busy_lo[i] && cyc <= busy_hi[i]) exp_busy = 1'b1;
    act = {bus.rx_byte, bus.byte_valid, bus.op_valid, bus.op_code, bus.op_err, bus.frame_err, bus.busy};
    exp = {m_byte, e.bv, e.ov, m_code, e.oe, e.fe, exp_busy};
    if (checking) begin
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d {rx_byte,bv,ov,code,oe,fe,busy} act=%h exp=%h", cyc, act, exp);
      end
    end
    if (bus.byte_valid === 1'b1) begin bv_cnt++; last_bv_cyc = cyc; end
    if (bus.op_valid === 1'b1) ov_cnt++;
    if (bus.op_err === 1'b1) oe_cnt++;
    if (bus.frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Predict the frame's outcome from the link rules, then drive it.
  // Called and returns on a falling edge; frames may follow back-to-back.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    ev_t        e;
    int         c0;
    logic [4:0] code;
    c0   = cyc;
    e    = '0;
    code = b[6:2];
    busy_lo.push_back(c0 + BUSY_ON);
    busy_hi.push_back(c0 + BUSY_END);
    if (!stop_ok) begin
      e.fe = 1'b1;
    end else begin
      e.bv = 1'b1;
      e.b  = b;
      if (b[1:0] == OP_TAG) begin
        if ($countones(code) == 1) begin
`ifdef OP_RX_CHANGE_ONLY_EN
          if (code != m_last) begin e.ov = 1'b1; e.code = code; end
          m_last = code;
`else
          e.ov = 1'b1; e.code = code;
`endif
        end else if (code != 5'b00000) begin
          e.oe = 1'b1;
        end else begin
`ifdef OP_RX_CHANGE_ONLY_EN
          m_last = 5'b00000;
`endif
        end
      end
    end
    sched[c0 + LAT] = e;
    bus.rx = 1'b0;
    repeat (OS) @(negedge uart_clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (OS) @(negedge uart_clk);
    end
    bus.rx = stop_ok;
    repeat (OS) @(negedge uart_clk);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge uart_clk);
  endtask

  int         c_start;
  int         bv0, ov0, oe0, fe0;
  logic [7:0] tb_byte;

  initial begin
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge uart_clk);
    rst      = 1'b0;
    checking = 1'b1;
    idle(8);

    // Reset state
    check("reset_rx_byte", bus.rx_byte, 8'h00);
    check("reset_op_code", bus.op_code, 5'b00000);
    check("reset_busy", bus.busy, 0);

    // 1: single PUT byte
    c_start = cyc;
    bv0 = bv_cnt; ov0 = ov_cnt;
    send_frame(8'h0A, 1'b1);
    idle(4);
    check("t1_latency", last_bv_cyc, c_start + LAT);
    check("t1_rx_byte", bus.rx_byte, 8'h0A);
    check("t1_op_code", bus.op_code, 5'b00010);
    check("t1_op_valid_cnt", ov_cnt - ov0, 1);

    // 2: back-to-back MOVE, tagged INTERACT (0x12), then untagged 0x10
    bv0 = bv_cnt; ov0 = ov_cnt;
    send_frame(8'h22, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h10, 1'b1);
    idle(4);
    check("t2_byte_valid_cnt", bv_cnt - bv0, 3);
    check("t2_op_valid_cnt", ov_cnt - ov0, 2);
    check("t2_op_code", bus.op_code, 5'b00100);

    // 3: IGNORE, multi-hot, wrong tag
    bv0 = bv_cnt; ov0 = ov_cnt; oe0 = oe_cnt;
    send_frame(8'h02, 1'b1);
    send_frame(8'h0E, 1'b1);
    send_frame(8'h0B, 1'b1);
    idle(4);
    check("t3_byte_valid_cnt", bv_cnt - bv0, 3);
    check("t3_op_valid_cnt", ov_cnt - ov0, 0);
    check("t3_op_err_cnt", oe_cnt - oe0, 1);
    check("t3_op_code_held", bus.op_code, 5'b00100);
    check("t3_rx_byte", bus.rx_byte, 8'h0B);

    // 4: start glitch, framing error, then recovery
    bv0 = bv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    bus.rx = 1'b0;
    repeat (6) @(negedge uart_clk);
    idle(40);
    check("t4_glitch_no_byte", bv_cnt - bv0, 0);
    send_frame(8'h42, 1'b0);
    idle(4);
    check("t4_frame_err_cnt", fe_cnt - fe0, 1);
    check("t4_rx_byte_held", bus.rx_byte, 8'h0B);
    idle(32);
    send_frame(8'h42, 1'b1);
    idle(4);
    check("t4_op_code", bus.op_code, 5'b10000);
    check("t4_op_valid_cnt", ov_cnt - ov0, 1);

    // 5: reset in the middle of bit 4 of 0x06 (line low), then a clean 0x06
    bv0 = bv_cnt; ov0 = ov_cnt;
    tb_byte = 8'h06;
    c_start = cyc;
    busy_lo.push_back(c_start + BUSY_ON);
    busy_hi.push_back(c_start + BUSY_END);
    bus.rx = 1'b0;
    repeat (OS) @(negedge uart_clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = tb_byte[i];
      repeat (OS) @(negedge uart_clk);
    end
    bus.rx = tb_byte[4];
    repeat (OS / 2) @(negedge uart_clk);
    rst     = 1'b1;
    rst_cyc = cyc + 1;
    busy_hi[busy_hi.size() - 1] = cyc;
`ifdef OP_RX_CHANGE_ONLY_EN
    m_last = 5'b00000;
`endif
    @(negedge uart_clk);
    rst = 1'b0;
    repeat (OS / 2 - 1) @(negedge uart_clk);
    for (int i = 5; i < 8; i++) begin
      bus.rx = tb_byte[i];
      repeat (OS) @(negedge uart_clk);
    end
    idle(40);
    check("t5_no_pulse", bv_cnt - bv0, 0);
    check("t5_rx_byte_cleared", bus.rx_byte, 8'h00);
    check("t5_op_code_cleared", bus.op_code, 5'b00000);
    send_frame(8'h06, 1'b1);
    idle(4);
    check("t5_op_code_get", bus.op_code, 5'b00001);
    check("t5_op_valid_cnt", ov_cnt - ov0, 1);

    // 6: repeated MOVE with an IGNORE in between
    bv0 = bv_cnt; ov0 = ov_cnt;
    send_frame(8'h22, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("t6_byte_valid_cnt", bv_cnt - bv0, 4);
`ifdef OP_RX_CHANGE_ONLY_EN
    check("t6_op_valid_cnt", ov_cnt - ov0, 2);
`else
    check("t6_op_valid_cnt", ov_cnt - ov0, 3);
`endif
    check("t6_op_code", bus.op_code, 5'b01000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
